bin2bcd_seq: RTL and testbench

Sequential, parametrised binary-to-BCD converter using the iterative shift-and-add-3 (double-dabble) algorithm.
- Processes one input bit per clock and reports the result through a start/busy/done handshake.
- Successor to the fixed 4-bit combinational add-3 cell: any input width, any digit count, overflow detection.
- Feeds the seven-segment display drivers from counters and ALU results.

---
 rtl/bin2bcd_pkg.sv | 18 +
 rtl/bcd_digit_adj.sv | 12 +
 rtl/bin2bcd_seq.sv | 116 +++++++++++
 tb/tb_bin2bcd_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential double-dabble binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Shift counter must hold the value BIN_W itself.
  function automatic int unsigned cnt_w(input int unsigned bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Single BCD digit add-3 adjust applied before each double-dabble shift.
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout_c
);

  // Inputs are always 0-9, so the 4-bit sum never wraps.
  assign dout_c = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = cnt_w(BIN_W);
  localparam int unsigned SR_W  = BCD_W + BIN_W;

  if (BIN_W < 1) begin : g_bad_bin_w
    $error("bin2bcd_seq: BIN_W must be >= 1");
  end
  if (DIGITS < 1) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS must be >= 1");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   sr_q, sr_d;
  logic [BCD_W-1:0]   scr_q, scr_d;
  logic               ovs_q, ovs_d;
  logic [BCD_W-1:0]   bcd_d;
  logic               ovf_d;
  logic               busy_d, done_d;

  logic [BCD_W-1:0]   adj;
  logic [SR_W-1:0]    shifted;
  logic               ovs_shift;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_adj
    bcd_digit_adj u_adj (
      .din    (scr_q[4*i +: 4]),
      .dout_c (adj[4*i +: 4])
    );
  end

  // Adjusted scratch and binary shift register move left together as one word.
  assign shifted   = {adj[BCD_W-2:0], sr_q, 1'b0};
  assign ovs_shift = ovs_q | adj[BCD_W-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    scr_d   = scr_q;
    ovs_d   = ovs_q;
    bcd_d   = bcd;
    ovf_d   = overflow;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sr_d    = bin;
          scr_d   = '0;
          ovs_d   = 1'b0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scr_d = shifted[SR_W-1 -: BCD_W];
        sr_d  = shifted[BIN_W-1:0];
        ovs_d = ovs_shift;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[SR_W-1 -: BCD_W];
          ovf_d   = ovs_shift;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sr_q     <= '0;
      scr_q    <= '0;
      ovs_q    <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
      scr_q    <= scr_d;
      ovs_q    <= ovs_d;
      bcd      <= bcd_d;
      overflow <= ovf_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq across three width/digit configurations.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a: 8 bits / 3 digits, b: 8 bits / 2 digits, c: 16 bits / 5 digits
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [7:0]  bin_a = '0, bin_b = '0;
  logic [15:0] bin_c = '0;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [11:0] bcd_a;
  logic [7:0]  bcd_b;
  logic [19:0] bcd_c;
  logic        ovf_a, ovf_b, ovf_c;

  bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .bin(bin_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .overflow(ovf_a));

  bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .bin(bin_b),
    .busy(busy_b), .done(done_b), .bcd(bcd_b), .overflow(ovf_b));

  bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .bin(bin_c),
    .busy(busy_c), .done(done_c), .bcd(bcd_c), .overflow(ovf_c));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          dut;
    logic [15:0] b;
    logic [19:0] exp_bcd;
    logic        exp_ovf;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input int d, input logic s, input logic [15:0] b);
    case (d)
      0: begin start_a = s; bin_a = b[7:0]; end
      1: begin start_b = s; bin_b = b[7:0]; end
      default: begin start_c = s; bin_c = b; end
    endcase
  endtask

  task automatic get_out(input int d, output logic bz, output logic dn,
                         output logic [19:0] bc, output logic ov);
    case (d)
      0: begin bz = busy_a; dn = done_a; bc = 20'(bcd_a); ov = ovf_a; end
      1: begin bz = busy_b; dn = done_b; bc = 20'(bcd_b); ov = ovf_b; end
      default: begin bz = busy_c; dn = done_c; bc = bcd_c; ov = ovf_c; end
    endcase
  endtask

  // Step one cycle at a time (sampling 1ns after each edge) until done, bounded.
  task automatic wait_done(input int d, output int lat);
    logic bz, dn, ov;
    logic [19:0] bc;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      get_out(d, bz, dn, bc, ov);
      if (dn) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic bz, dn, ov;
    logic [19:0] bc;
    int lat, nbusy;
    @(negedge clk);
    set_in(v.dut, 1'b1, v.b);
    @(posedge clk); #1;
    set_in(v.dut, 1'b0, 16'd0);
    nbusy = 0;
    lat = -1;
    for (int k = 0; k <= 40; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      get_out(v.dut, bz, dn, bc, ov);
      if (bz) nbusy++;
      if (dn) begin
        lat = k;
        break;
      end
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " busy cycles"}, 32'(nbusy), 32'(v.lat));
    check({v.name, " bcd"}, 32'(bc), 32'(v.exp_bcd));
    check({v.name, " overflow"}, 32'(ov), 32'(v.exp_ovf));
    @(posedge clk); #1;
    get_out(v.dut, bz, dn, bc, ov);
    check({v.name, " done one cycle"}, 32'(dn), 32'd0);
  endtask

  initial begin
    logic bz, dn, ov;
    logic [19:0] bc;
    int lat, cnt;

    vecs.push_back('{0, 16'd255,   20'h00255, 1'b0, 8,  "a 255"});
    vecs.push_back('{0, 16'd1,     20'h00001, 1'b0, 8,  "a 1"});
    vecs.push_back('{0, 16'd10,    20'h00010, 1'b0, 8,  "a 10"});
    vecs.push_back('{0, 16'd200,   20'h00200, 1'b0, 8,  "a 200"});
    vecs.push_back('{1, 16'd200,   20'h00000, 1'b1, 8,  "b 200"});
    vecs.push_back('{1, 16'd99,    20'h00099, 1'b0, 8,  "b 99"});
    vecs.push_back('{1, 16'd100,   20'h00000, 1'b1, 8,  "b 100"});
    vecs.push_back('{1, 16'd255,   20'h00055, 1'b1, 8,  "b 255"});
    vecs.push_back('{2, 16'd65535, 20'h65535, 1'b0, 16, "c 65535"});
    vecs.push_back('{2, 16'd10000, 20'h10000, 1'b0, 16, "c 10000"});
    vecs.push_back('{2, 16'd0,     20'h00000, 1'b0, 16, "c 0"});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy_a), 32'd0);
    check("reset done", 32'(done_a), 32'd0);
    check("reset bcd", 32'(bcd_a), 32'd0);
    check("reset overflow", 32'(ovf_a), 32'd0);
    check("reset bcd b/c", 32'(bcd_b) | 32'(bcd_c), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back: 0 then 99, second start raised while in DONE
    @(negedge clk);
    set_in(0, 1'b1, 16'd0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd0);
    wait_done(0, lat);
    check("b2b first latency", 32'(lat), 32'd8);
    check("b2b first bcd", 32'(bcd_a), 32'h000);
    set_in(0, 1'b1, 16'd99);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd0);
    check("b2b accept in done busy", 32'(busy_a), 32'd1);
    check("b2b accept in done done", 32'(done_a), 32'd0);
    wait_done(0, lat);
    check("b2b done spacing", 32'(lat + 1), 32'd9);
    check("b2b second bcd", 32'(bcd_a), 32'h099);

    // Start while busy is ignored; bcd holds until the final shift
    @(negedge clk);
    set_in(0, 1'b1, 16'd128);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd0);
    check("bcd holds at accept", 32'(bcd_a), 32'h099);
    repeat (2) begin @(posedge clk); #1; end
    set_in(0, 1'b1, 16'd7);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd0);
    wait_done(0, lat);
    check("busy start latency", 32'(lat), 32'd5);
    check("busy start bcd", 32'(bcd_a), 32'h128);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) cnt++;
    end
    check("busy start not queued", 32'(cnt), 32'd0);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    set_in(0, 1'b1, 16'd200);
    @(posedge clk); #1;
    set_in(0, 1'b0, 16'd0);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    get_out(0, bz, dn, bc, ov);
    check("abort busy", 32'(bz), 32'd0);
    check("abort done", 32'(dn), 32'd0);
    check("abort bcd", 32'(bc), 32'd0);
    check("abort overflow", 32'(ov), 32'd0);
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) cnt++;
    end
    check("abort no late done", 32'(cnt), 32'd0);

    // Converter still works after the abort
    run_vec('{0, 16'd42, 20'h00042, 1'b0, 8, "a 42 after abort"});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
